mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register for the 32-bit MIPS core; consumes the EX/MEM control bundle
//  (MemtoReg, RegWrite, MemRead) plus ALU result, destination register and data-memory read data.
//  - Aligns and extends load data, then selects the writeback value.
//  - Registers everything into the WB stage; supports stall/flush; counts retired instructions.
//  - Drives register-file write port and WB-stage forwarding source.

---
 rtl/mips_pkg.sv | 14 +
 rtl/load_extend.sv | 36 +++
 rtl/mem_wb_stage.sv | 95 +++++++++
 tb/tb_mem_wb_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the load-size encoding used by the MEM/WB stage.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } load_size_e;
endpackage

// File: rtl/load_extend.sv
// Big-endian load lane selection and sign/zero extension, plus raw alignment check.
module load_extend
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  load_size_e        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] load_val_o,
    output logic              misalign_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Byte 0 lives in the most significant lane.
        case (offset_i)
            2'd0:    byte_sel = rdata_i[31:24];
            2'd1:    byte_sel = rdata_i[23:16];
            2'd2:    byte_sel = rdata_i[15:8];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (size_i)
            LS_BYTE: load_val_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            LS_HALF: load_val_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            default: load_val_o = rdata_i;
        endcase
    end

    // Unqualified: the stage gates this with MemRead/valid.
    assign misalign_o = ((size_i == LS_HALF) && offset_i[0])
                      || ((size_i == LS_WORD) && (offset_i != 2'd0))
                      || (size_i == LS_RSVD);
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects writeback data, qualifies the RF write, counts retirements.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_MEM,
    input  logic              MemtoReg_MEM,
    input  logic              RegWrite_MEM,
    input  logic              MemRead_MEM,
    input  logic [1:0]        load_size_MEM,
    input  logic              load_uns_MEM,
    input  logic [DATA_W-1:0] alu_result_MEM,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic [DATA_W-1:0] mem_rdata_MEM,
    input  logic              stall,
    input  logic              flush,
    output logic              valid_WB,
    output logic              RegWrite_WB,
    output logic [REG_AW-1:0] rd_WB,
    output logic [DATA_W-1:0] wdata_WB,
    output logic              misalign_WB,
    output logic [CNT_W-1:0]  retired_cnt
);
    logic [DATA_W-1:0] load_val;
    logic              misalign_raw;

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    load_extend u_load_extend (
        .rdata_i    (mem_rdata_MEM),
        .offset_i   (alu_result_MEM[1:0]),
        .size_i     (load_size_e'(load_size_MEM)),
        .uns_i      (load_uns_MEM),
        .load_val_o (load_val),
        .misalign_o (misalign_raw)
    );

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            mis_d   = 1'b0;
        end else if (!stall) begin
            valid_d = valid_MEM;
            rd_d    = rd_MEM;
            wdata_d = MemtoReg_MEM ? load_val : alu_result_MEM;
            mis_d   = MemRead_MEM & valid_MEM & misalign_raw;
            // A misaligned load still retires, but never writes the register file.
            we_d    = valid_MEM & RegWrite_MEM & (rd_MEM != REG_ZERO[REG_AW-1:0]) & ~mis_d;
            if (valid_MEM)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_WB    = valid_q;
    assign RegWrite_WB = we_q;
    assign rd_WB       = rd_q;
    assign wdata_WB    = wdata_q;
    assign misalign_WB = mis_q;
    assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a 4-bit-counter twin instance exercises counter wrap.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_MEM, MemtoReg_MEM, RegWrite_MEM, MemRead_MEM, load_uns_MEM;
    logic [1:0]  load_size_MEM;
    logic [31:0] alu_result_MEM, mem_rdata_MEM;
    logic [4:0]  rd_MEM;
    logic        stall, flush;
    logic        valid_WB, RegWrite_WB, misalign_WB;
    logic [4:0]  rd_WB;
    logic [31:0] wdata_WB, retired_cnt;
    logic        s_valid_WB, s_RegWrite_WB, s_misalign_WB;
    logic [4:0]  s_rd_WB;
    logic [31:0] s_wdata_WB;
    logic [3:0]  s_retired_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .valid_MEM(valid_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .load_size_MEM(load_size_MEM),
        .load_uns_MEM(load_uns_MEM), .alu_result_MEM(alu_result_MEM), .rd_MEM(rd_MEM),
        .mem_rdata_MEM(mem_rdata_MEM), .stall(stall), .flush(flush), .valid_WB(valid_WB),
        .RegWrite_WB(RegWrite_WB), .rd_WB(rd_WB), .wdata_WB(wdata_WB),
        .misalign_WB(misalign_WB), .retired_cnt(retired_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .valid_MEM(valid_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .load_size_MEM(load_size_MEM),
        .load_uns_MEM(load_uns_MEM), .alu_result_MEM(alu_result_MEM), .rd_MEM(rd_MEM),
        .mem_rdata_MEM(mem_rdata_MEM), .stall(stall), .flush(flush), .valid_WB(s_valid_WB),
        .RegWrite_WB(s_RegWrite_WB), .rd_WB(s_rd_WB), .wdata_WB(s_wdata_WB),
        .misalign_WB(s_misalign_WB), .retired_cnt(s_retired_cnt)
    );

    // Inputs change at negedge; one call advances past a posedge to the next negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [4:0] rd);
        valid_MEM = 1'b1; MemtoReg_MEM = 1'b1; RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1;
        load_size_MEM = size; load_uns_MEM = uns; alu_result_MEM = addr;
        mem_rdata_MEM = rdata; rd_MEM = rd;
    endtask

    task automatic drive_alu(input logic [31:0] res, input logic [4:0] rd);
        valid_MEM = 1'b1; MemtoReg_MEM = 1'b0; RegWrite_MEM = 1'b1; MemRead_MEM = 1'b0;
        load_size_MEM = 2'd2; load_uns_MEM = 1'b0; alu_result_MEM = res;
        mem_rdata_MEM = 32'h5555_AAAA; rd_MEM = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_alu(32'h1234_5678, 5'd3);
        cycle(); cycle();
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB, rd_WB, wdata_WB, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL reset: v=%b we=%b mis=%b rd=%0d wd=%h cnt=%0d, required all 0",
                     valid_WB, RegWrite_WB, misalign_WB, rd_WB, wdata_WB, retired_cnt);
        end
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_loads();
        // lb off=1 -> 0x80 sign-extended
        drive_load(2'd0, 1'b0, 32'h0000_1001, 32'h1280_FF00, 5'd8);
        cycle(); exp_cnt++;
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB, rd_WB, wdata_WB} !== {3'b110, 5'd8, 32'hFFFF_FF80}) begin
            errors++;
            $display("FAIL lb: v=%b we=%b mis=%b rd=%0d wd=%h, required 1 1 0 8 ffffff80",
                     valid_WB, RegWrite_WB, misalign_WB, rd_WB, wdata_WB);
        end
        drive_load(2'd0, 1'b1, 32'h0000_1001, 32'h1280_FF00, 5'd9);
        cycle(); exp_cnt++;
        checks++;
        if (wdata_WB !== 32'h0000_0080 || rd_WB !== 5'd9) begin
            errors++; $display("FAIL lbu: wd=%h rd=%0d, required 00000080 9", wdata_WB, rd_WB);
        end
        drive_load(2'd1, 1'b0, 32'h0000_2002, 32'h1234_8001, 5'd10);
        cycle(); exp_cnt++;
        checks++;
        if (wdata_WB !== 32'hFFFF_8001 || RegWrite_WB !== 1'b1) begin
            errors++; $display("FAIL lh_off2: wd=%h we=%b, required ffff8001 1", wdata_WB, RegWrite_WB);
        end
        drive_load(2'd1, 1'b1, 32'h0000_2000, 32'h8234_8001, 5'd11);
        cycle(); exp_cnt++;
        checks++;
        if (wdata_WB !== 32'h0000_8234) begin
            errors++; $display("FAIL lhu_off0: wd=%h, required 00008234", wdata_WB);
        end
        drive_load(2'd0, 1'b0, 32'h0000_0003, 32'h1234_5677, 5'd12);
        cycle(); exp_cnt++;
        checks++;
        if (wdata_WB !== 32'h0000_0077) begin
            errors++; $display("FAIL lb_off3: wd=%h, required 00000077", wdata_WB);
        end
        drive_load(2'd2, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 5'd13);
        cycle(); exp_cnt++;
        checks++;
        if (wdata_WB !== 32'hCAFE_F00D || misalign_WB !== 1'b0 || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL lw: wd=%h mis=%b cnt=%0d, required cafef00d 0 %0d",
                               wdata_WB, misalign_WB, retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_misalign_and_r0();
        drive_load(2'd2, 1'b0, 32'h0000_0042, 32'hCAFE_F00D, 5'd14);
        cycle(); exp_cnt++;
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB} !== 3'b101 || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL lw_misalign: v=%b we=%b mis=%b cnt=%0d, required 1 0 1 %0d",
                               valid_WB, RegWrite_WB, misalign_WB, retired_cnt, exp_cnt);
        end
        drive_load(2'd3, 1'b0, 32'h0000_0000, 32'h1111_2222, 5'd15);
        cycle(); exp_cnt++;
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB} !== 3'b101) begin
            errors++; $display("FAIL size3: v=%b we=%b mis=%b, required 1 0 1",
                               valid_WB, RegWrite_WB, misalign_WB);
        end
        // Not a load: odd half offset is not checked, load value still used.
        drive_load(2'd1, 1'b0, 32'h0000_0003, 32'h1234_8001, 5'd16);
        MemRead_MEM = 1'b0;
        cycle(); exp_cnt++;
        checks++;
        if ({RegWrite_WB, misalign_WB} !== 2'b10 || wdata_WB !== 32'hFFFF_8001) begin
            errors++; $display("FAIL m2r_noread: we=%b mis=%b wd=%h, required 1 0 ffff8001",
                               RegWrite_WB, misalign_WB, wdata_WB);
        end
        drive_alu(32'h0000_0777, 5'd0);
        cycle(); exp_cnt++;
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB} !== 3'b100 || wdata_WB !== 32'h0000_0777) begin
            errors++; $display("FAIL rd0: v=%b we=%b mis=%b wd=%h, required 1 0 0 00000777",
                               valid_WB, RegWrite_WB, misalign_WB, wdata_WB);
        end
        drive_alu(32'h0000_0999, 5'd7);
        valid_MEM = 1'b0;
        cycle();
        checks++;
        if ({valid_WB, RegWrite_WB} !== 2'b00 || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL bubble: v=%b we=%b cnt=%0d, required 0 0 %0d",
                               valid_WB, RegWrite_WB, retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_stall();
        drive_alu(32'hDEAD_BEEF, 5'd5);
        cycle(); exp_cnt++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alu(32'h0000_1000 + i, 5'd20 + 5'(i));
            cycle();
            checks++;
            if ({valid_WB, RegWrite_WB, rd_WB, wdata_WB} !== {2'b11, 5'd5, 32'hDEAD_BEEF}
                || retired_cnt !== exp_cnt) begin
                errors++; $display("FAIL stall_%0d: v=%b we=%b rd=%0d wd=%h cnt=%0d, required 1 1 5 deadbeef %0d",
                                   i, valid_WB, RegWrite_WB, rd_WB, wdata_WB, retired_cnt, exp_cnt);
            end
        end
        stall = 1'b0;
        drive_alu(32'h0000_0042, 5'd6);
        cycle(); exp_cnt++;
        checks++;
        if (wdata_WB !== 32'h0000_0042 || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL unstall: wd=%h cnt=%0d, required 00000042 %0d", wdata_WB, retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush_and_reset();
        stall = 1'b1; flush = 1'b1;
        drive_alu(32'h0000_0ABC, 5'd9);
        cycle();
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB} !== 3'b000 || rd_WB !== 5'd6
            || wdata_WB !== 32'h0000_0042 || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL flush_stall: v=%b we=%b mis=%b rd=%0d wd=%h cnt=%0d, required 0 0 0 6 00000042 %0d",
                               valid_WB, RegWrite_WB, misalign_WB, rd_WB, wdata_WB, retired_cnt, exp_cnt);
        end
        // Flush also clears a sticky misalign flag.
        stall = 1'b0; flush = 1'b0;
        drive_load(2'd1, 1'b0, 32'h0000_0001, 32'h0, 5'd3);
        cycle(); exp_cnt++;
        flush = 1'b1;
        cycle();
        checks++;
        if ({valid_WB, misalign_WB} !== 2'b00) begin
            errors++; $display("FAIL flush_mis: v=%b mis=%b, required 0 0", valid_WB, misalign_WB);
        end
        flush = 1'b0;
        drive_alu(32'h0000_0321, 5'd4);
        cycle(); exp_cnt++;
        stall = 1'b1; rst = 1'b1;
        cycle();
        checks++;
        if ({valid_WB, RegWrite_WB, misalign_WB, rd_WB, wdata_WB, retired_cnt} !== '0) begin
            errors++; $display("FAIL rst_stall: v=%b we=%b rd=%0d wd=%h cnt=%0d, required all 0",
                               valid_WB, RegWrite_WB, rd_WB, wdata_WB, retired_cnt);
        end
        rst = 1'b0; stall = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_counter_wrap();
        drive_alu(32'h0000_0001, 5'd1);
        for (int i = 0; i < 15; i++) cycle();
        exp_cnt = 15;
        checks++;
        if (s_retired_cnt !== 4'hF || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL cnt_max: small=%0d wide=%0d, required 15 15", s_retired_cnt, retired_cnt);
        end
        cycle(); exp_cnt++;
        checks++;
        if (s_retired_cnt !== 4'h0 || retired_cnt !== exp_cnt || s_valid_WB !== 1'b1) begin
            errors++; $display("FAIL cnt_wrap: small=%0d wide=%0d v=%b, required 0 16 1",
                               s_retired_cnt, retired_cnt, s_valid_WB);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_loads();
        test_misalign_and_r0();
        test_stall();
        test_flush_and_reset();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
